// File: rtl/adc_ad7476_read_mmi_pkg.sv
// Shared types and constants for the AD7476 SPI reader: register map, FSM states, widths.
package adc_ad7476_pkg;

   localparam int ADC_DATA_W    = 12;
   localparam int SPI_FRAME_LEN = 16;
   localparam int MMI_DATA_W    = 16;
   localparam int MMI_ADDR_W    = 15;

   typedef enum logic [MMI_ADDR_W-1:0] {
      ADDR_MODULE_VERSION = 15'd0,
      ADDR_CTRL           = 15'd1,
      ADDR_SAMPLE_PERIOD  = 15'd2,
      ADDR_LAST_SAMPLE    = 15'd3,
      ADDR_SAMPLE_COUNT   = 15'd4,
      ADDR_STATUS         = 15'd5,
      ADDR_MIN_SAMPLE     = 15'd6,
      ADDR_MAX_SAMPLE     = 15'd7
   } reg_addr_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_XFER    = 2'd1,
      ST_CAPTURE = 2'd2
   } state_e;

   // Zero-extend a sample into a register word.
   function automatic logic [MMI_DATA_W-1:0] sample_word(input logic [ADC_DATA_W-1:0] s);
      return {{(MMI_DATA_W-ADC_DATA_W){1'b0}}, s};
   endfunction

endpackage

// File: rtl/adc_ad7476_read_mmi_if.sv
// Bus interfaces: MMI register port (single-cycle write, 1-cycle registered read) and SPI driver command port.
interface MemoryMap_int #(
   parameter int DATALEN = 16,
   parameter int ADDRLEN = 15
);
   logic [ADDRLEN-1:0] waddr;
   logic [DATALEN-1:0] wdata;
   logic               wvalid;
   logic               wready;
   logic [ADDRLEN-1:0] raddr;
   logic               rreq;
   logic [DATALEN-1:0] rdata;
   logic               rvalid;

   modport Master (output waddr, wdata, wvalid, raddr, rreq,
                   input  wready, rdata, rvalid);
   modport Slave  (input  waddr, wdata, wvalid, raddr, rreq,
                   output wready, rdata, rvalid);
endinterface

// rdy is high while the driver is idle; it drops during a frame and rises with rx_data valid.
interface SPIDriver_int #(
   parameter int MAXLEN = 16,
   parameter int SSNLEN = 1
);
   logic              start_cmd;
   logic [MAXLEN-1:0] tx_data;
   logic [SSNLEN-1:0] ssn;
   logic              rdy;
   logic [MAXLEN-1:0] rx_data;

   modport Master (output start_cmd, tx_data, ssn,
                   input  rdy, rx_data);
   modport Slave  (input  start_cmd, tx_data, ssn,
                   output rdy, rx_data);
endinterface

// File: rtl/adc_ad7476_read_mmi_timer.sv
// Sample-period counter: counts 0..period-1 while enabled and fires a trigger on the terminal count.
module adc_sample_timer (
   input  logic        clk,
   input  logic        aresetn,
   input  logic        i_enable,
   input  logic        i_restart,
   input  logic [15:0] i_period,
   output logic        o_trigger
);

   logic [15:0] r_count;
   logic        w_terminal;

   // A zero period makes every cycle terminal, giving back-to-back triggers.
   assign w_terminal = (i_period == 16'd0) || (r_count == (i_period - 16'd1));
   assign o_trigger  = i_enable && !i_restart && w_terminal;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_count <= '0;
      end else if (!i_enable || i_restart || w_terminal) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 16'd1;
      end
   end

endmodule

// File: rtl/adc_ad7476_read_mmi.sv
// AD7476 reader: periodic/one-shot SPI conversions, 12-bit sample capture, MMI register block.
// Define ADC_MINMAX_EN to add MIN_SAMPLE/MAX_SAMPLE tracking registers at addresses 6 and 7.
module adc_ad7476_read_mmi
   import adc_ad7476_pkg::*;
#(
   parameter logic [15:0] MODULE_VERSION = 16'd1,
   parameter logic [15:0] PERIOD_DEFAULT = 16'd1000,
   parameter logic        EN_DEFAULT     = 1'b0,
   parameter int          SPI_SS_BIT     = 0
) (
   input  logic                  clk,
   input  logic                  aresetn,
   MemoryMap_int.Slave           mmi,
   SPIDriver_int.Master          spi_cmd,
   output logic [ADC_DATA_W-1:0] sample,
   output logic                  sample_valid_stb,
   output logic                  busy
);

   state_e                  r_state;
   state_e                  w_next_state;
   logic                    r_enable;
   logic [15:0]             r_period;
   logic [ADC_DATA_W-1:0]   r_sample;
   logic [15:0]             r_count;
   logic                    r_overrun;
   logic                    r_rdy_d;
   logic [MMI_DATA_W-1:0]   r_rdata;
   logic                    r_rvalid;
   logic [MMI_DATA_W-1:0]   w_rdata;

   logic w_wr_ctrl, w_wr_period, w_wr_status;
   logic w_oneshot, w_timer_trig, w_trigger;
   logic w_rdy_rise, w_start, w_capture, w_strobe, w_overrun_set;
   logic [ADC_DATA_W-1:0] w_rx_sample;
   logic w_unused_rx_hi;

   assign w_wr_ctrl   = mmi.wvalid && (mmi.waddr == ADDR_CTRL);
   assign w_wr_period = mmi.wvalid && (mmi.waddr == ADDR_SAMPLE_PERIOD);
   assign w_wr_status = mmi.wvalid && (mmi.waddr == ADDR_STATUS);

   // Oneshot and timer trigger in the same cycle merge into a single trigger.
   assign w_oneshot     = w_wr_ctrl && mmi.wdata[1];
   assign w_trigger     = w_oneshot || w_timer_trig;
   assign w_overrun_set = w_trigger && (r_state != ST_IDLE);
   assign w_rdy_rise    = spi_cmd.rdy && !r_rdy_d;

   // The converter shifts out leading zeros ahead of the 12 data bits.
   assign w_rx_sample    = spi_cmd.rx_data[ADC_DATA_W-1:0];
   assign w_unused_rx_hi = ^spi_cmd.rx_data[SPI_FRAME_LEN-1:ADC_DATA_W];

   adc_sample_timer u_timer (
      .clk       (clk),
      .aresetn   (aresetn),
      .i_enable  (r_enable),
      .i_restart (w_wr_period),
      .i_period  (r_period),
      .o_trigger (w_timer_trig)
   );

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= ST_IDLE;
         r_rdy_d <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_rdy_d <= spi_cmd.rdy;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      w_capture    = 1'b0;
      w_strobe     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_trigger) w_next_state = ST_XFER;
         end
         ST_XFER: begin
            w_start = 1'b1;
            if (w_rdy_rise) begin
               w_capture    = 1'b1;
               w_next_state = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            w_strobe     = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_enable  <= EN_DEFAULT;
         r_period  <= PERIOD_DEFAULT;
         r_sample  <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_wr_ctrl)   r_enable <= mmi.wdata[0];
         if (w_wr_period) r_period <= mmi.wdata;
         if (w_capture) begin
            r_sample <= w_rx_sample;
            r_count  <= r_count + 16'd1;
         end
         // A new overrun in the clearing cycle wins over the W1C.
         r_overrun <= w_overrun_set || (r_overrun && !(w_wr_status && mmi.wdata[0]));
      end
   end

`ifdef ADC_MINMAX_EN
   logic [ADC_DATA_W-1:0] r_min;
   logic [ADC_DATA_W-1:0] r_max;
   logic                  w_wr_minmax;

   assign w_wr_minmax = mmi.wvalid &&
                        ((mmi.waddr == ADDR_MIN_SAMPLE) || (mmi.waddr == ADDR_MAX_SAMPLE));

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_min <= '1;
         r_max <= '0;
      end else if (w_wr_minmax) begin
         r_min <= '1;
         r_max <= '0;
      end else if (w_capture) begin
         if (w_rx_sample < r_min) r_min <= w_rx_sample;
         if (w_rx_sample > r_max) r_max <= w_rx_sample;
      end
   end
`endif

   always_comb begin
      w_rdata = '0;
      case (mmi.raddr)
         ADDR_MODULE_VERSION: w_rdata = MODULE_VERSION;
         ADDR_CTRL:           w_rdata = {15'd0, r_enable};
         ADDR_SAMPLE_PERIOD:  w_rdata = r_period;
         ADDR_LAST_SAMPLE:    w_rdata = sample_word(r_sample);
         ADDR_SAMPLE_COUNT:   w_rdata = r_count;
         ADDR_STATUS:         w_rdata = {15'd0, r_overrun};
`ifdef ADC_MINMAX_EN
         ADDR_MIN_SAMPLE:     w_rdata = sample_word(r_min);
         ADDR_MAX_SAMPLE:     w_rdata = sample_word(r_max);
`endif
         default:             w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= mmi.rreq;
         if (mmi.rreq) r_rdata <= w_rdata;
      end
   end

   assign mmi.wready = 1'b1;
   assign mmi.rdata  = r_rdata;
   assign mmi.rvalid = r_rvalid;

   assign spi_cmd.start_cmd = w_start;
   assign spi_cmd.tx_data   = '0;
   always_comb begin
      spi_cmd.ssn             = '0;
      spi_cmd.ssn[SPI_SS_BIT] = w_start;
   end

   assign sample           = r_sample;
   assign sample_valid_stb = w_strobe;
   assign busy             = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adc_ad7476_read_mmi.sv
// Directed bench for adc_ad7476_read_mmi with a behavioural SPI driver returning a programmable word.
module tb_adc_ad7476_read_mmi;
   import adc_ad7476_pkg::*;

   localparam int FRAME_CYC = 20;

   logic clk     = 1'b0;
   logic aresetn = 1'b0;
   always #5 clk = ~clk;

   MemoryMap_int #(.DATALEN(16), .ADDRLEN(15)) mmi_if ();
   SPIDriver_int #(.MAXLEN(16), .SSNLEN(1))    spi_if ();

   logic [11:0] sample;
   logic        sample_valid_stb;
   logic        busy;

   adc_ad7476_read_mmi dut (
      .clk              (clk),
      .aresetn          (aresetn),
      .mmi              (mmi_if),
      .spi_cmd          (spi_if),
      .sample           (sample),
      .sample_valid_stb (sample_valid_stb),
      .busy             (busy)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [15:0] spi_resp = 16'h0000;

   // SPI driver model: accepts a start while idle, runs FRAME_CYC cycles, then returns spi_resp.
   initial begin
      bit armed;
      armed          = 1'b1;
      spi_if.rdy     = 1'b1;
      spi_if.rx_data = 16'h0000;
      forever begin
         @(negedge clk);
         if (spi_if.start_cmd && spi_if.rdy && armed) begin
            spi_if.rdy = 1'b0;
            repeat (FRAME_CYC) @(negedge clk);
            spi_if.rx_data = spi_resp;
            spi_if.rdy     = 1'b1;
            armed          = 1'b0;
         end else if (!spi_if.start_cmd) begin
            armed = 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("  ok   %s = %h", tag, got);
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic mmi_write(input logic [14:0] a, input logic [15:0] d);
      mmi_if.waddr  = a;
      mmi_if.wdata  = d;
      mmi_if.wvalid = 1'b1;
      @(negedge clk);
      mmi_if.wvalid = 1'b0;
      $display("  wr   addr %0d <= %h", a, d);
   endtask

   task automatic mmi_read(input logic [14:0] a, output logic [15:0] d);
      mmi_if.raddr = a;
      mmi_if.rreq  = 1'b1;
      @(negedge clk);
      mmi_if.rreq  = 1'b0;
      d = mmi_if.rdata;
      $display("  rd   addr %0d => %h", a, d);
   endtask

   task automatic rd_check(input string tag, input logic [14:0] a, input logic [15:0] exp);
      logic [15:0] d;
      mmi_read(a, d);
      check(tag, {16'h0, d}, {16'h0, exp});
   endtask

   task automatic wait_strobe(input int budget, output bit seen, output logic [11:0] smp);
      seen = 1'b0;
      smp  = '0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (sample_valid_stb) begin
            seen = 1'b1;
            smp  = sample;
         end
      end
   endtask

   task automatic count_strobes(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (sample_valid_stb) n++;
      end
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (!busy) ok = 1'b1;
      end
   endtask

   // Wait for the XFER phase: busy without the capture strobe.
   task automatic wait_xfer(input int budget, output bit ok, inout int nstb);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (sample_valid_stb) nstb++;
         else if (busy) ok = 1'b1;
      end
   endtask

   task automatic do_oneshot(input logic [15:0] resp);
      bit          seen, ok;
      logic [11:0] smp;
      spi_resp = resp;
      mmi_write(ADDR_CTRL, 16'h0002);
      wait_strobe(100, seen, smp);
      check("oneshot_stb", {31'd0, seen}, 32'd1);
      check("oneshot_smp", {20'd0, smp}, {20'd0, resp[11:0]});
      wait_idle(50, ok);
   endtask

   function automatic logic [15:0] reset_reg(input int a);
      case (a)
         0: return 16'd1;
         2: return 16'd1000;
`ifdef ADC_MINMAX_EN
         6: return 16'h0FFF;
`endif
         default: return 16'h0000;
      endcase
   endfunction

   initial begin
      bit          seen, ok;
      logic [11:0] smp;
      int          nstb, last, gap, first_gap, bad, extra, cnt_base;

      mmi_if.waddr  = '0;
      mmi_if.wdata  = '0;
      mmi_if.wvalid = 1'b0;
      mmi_if.raddr  = '0;
      mmi_if.rreq   = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_sample", {20'd0, sample}, 32'd0);
      check("rst_stb", {31'd0, sample_valid_stb}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_start", {31'd0, spi_if.start_cmd}, 32'd0);
      check("rst_tx", {16'd0, spi_if.tx_data}, 32'd0);
      aresetn = 1'b1;
      @(negedge clk);
      rd_check("rst_version", ADDR_MODULE_VERSION, 16'd1);
      rd_check("rst_ctrl", ADDR_CTRL, 16'd0);
      rd_check("rst_period", ADDR_SAMPLE_PERIOD, 16'd1000);
      rd_check("rst_count", ADDR_SAMPLE_COUNT, 16'd0);
      rd_check("rst_status", ADDR_STATUS, 16'd0);

      // Oneshot capture
      do_oneshot(16'h0ABC);
      check("oneshot_port", {20'd0, sample}, 32'h0ABC);
      rd_check("oneshot_last", ADDR_LAST_SAMPLE, 16'h0ABC);
      rd_check("oneshot_count", ADDR_SAMPLE_COUNT, 16'd1);
      rd_check("oneshot_ctrl", ADDR_CTRL, 16'd0);

      // Periodic sampling; upper nibble of the SPI word must be dropped
      spi_resp = 16'hF123;
      mmi_write(ADDR_SAMPLE_PERIOD, 16'd200);
      mmi_write(ADDR_CTRL, 16'h0001);
      nstb = 0; last = -1; bad = 0; first_gap = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (sample_valid_stb) begin
            if (last >= 0) begin
               gap = c - last;
               if (nstb == 1) first_gap = gap;
               if (gap != 200) bad++;
            end
            if (sample !== 12'h123) bad++;
            last = c;
            nstb++;
         end
      end
      check("period_gap", first_gap, 32'd200);
      check("period_bad", bad, 32'd0);
      check("period_nstb", {31'd0, (nstb == 9 || nstb == 10)}, 32'd1);

      // Disable mid-frame: the current frame still completes, then nothing more
      wait_xfer(300, ok, nstb);
      check("midframe_xfer", {31'd0, ok}, 32'd1);
      mmi_write(ADDR_CTRL, 16'h0000);
      wait_strobe(100, seen, smp);
      check("midframe_stb", {31'd0, seen}, 32'd1);
      if (seen) nstb++;
      count_strobes(500, extra);
      check("disabled_quiet", extra, 32'd0);
      rd_check("period_count", ADDR_SAMPLE_COUNT, 16'(1 + nstb));
      rd_check("period_status", ADDR_STATUS, 16'd0);
      cnt_base = 1 + nstb;

      // Overrun: second oneshot while a frame is in flight is dropped
      mmi_write(ADDR_SAMPLE_PERIOD, 16'd0);
      spi_resp = 16'h0456;
      mmi_write(ADDR_CTRL, 16'h0002);
      mmi_write(ADDR_CTRL, 16'h0002);
      wait_strobe(100, seen, smp);
      check("ovr_stb", {31'd0, seen}, 32'd1);
      count_strobes(60, extra);
      check("ovr_dropped", extra, 32'd0);
      rd_check("ovr_status", ADDR_STATUS, 16'd1);
      rd_check("ovr_count", ADDR_SAMPLE_COUNT, 16'(cnt_base + 1));
      mmi_write(ADDR_STATUS, 16'h0001);
      rd_check("ovr_w1c", ADDR_STATUS, 16'd0);

      // W1C in a cycle that also sets overrun: set wins
      nstb = 0;
      mmi_write(ADDR_CTRL, 16'h0001);
      repeat (40) @(negedge clk);
      wait_xfer(100, ok, nstb);
      mmi_write(ADDR_STATUS, 16'h0001);
      rd_check("ovr_set_wins", ADDR_STATUS, 16'd1);
      mmi_write(ADDR_CTRL, 16'h0000);
      wait_idle(100, ok);
      repeat (5) @(negedge clk);
      mmi_write(ADDR_STATUS, 16'h0001);
      rd_check("ovr_cleared", ADDR_STATUS, 16'd0);

      // Async reset in the middle of a transfer
      mmi_write(ADDR_SAMPLE_PERIOD, 16'd50);
      spi_resp = 16'h0777;
      mmi_write(ADDR_CTRL, 16'h0002);
      repeat (5) @(negedge clk);
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      aresetn = 1'b0;
      #1;
      check("arst_start", {31'd0, spi_if.start_cmd}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      aresetn = 1'b1;
      count_strobes(60, extra);
      check("arst_no_stb", extra, 32'd0);
      check("arst_sample", {20'd0, sample}, 32'd0);
      rd_check("arst_period", ADDR_SAMPLE_PERIOD, 16'd1000);
      rd_check("arst_count", ADDR_SAMPLE_COUNT, 16'd0);
      rd_check("arst_last", ADDR_LAST_SAMPLE, 16'd0);

      // Random reads against the post-reset register image
      for (int i = 0; i < 12; i++) begin
         int a;
         a = int'($urandom_range(0, 15));
         rd_check($sformatf("rand_rd_%0d", a), 15'(a), reset_reg(a));
      end

      // Min/max tracking
      do_oneshot(16'h0100);
      do_oneshot(16'h0050);
      do_oneshot(16'h0300);
      rd_check("mm_last", ADDR_LAST_SAMPLE, 16'h0300);
`ifdef ADC_MINMAX_EN
      rd_check("mm_min", ADDR_MIN_SAMPLE, 16'h0050);
      rd_check("mm_max", ADDR_MAX_SAMPLE, 16'h0300);
      mmi_write(ADDR_MIN_SAMPLE, 16'h0000);
      rd_check("mm_min_init", ADDR_MIN_SAMPLE, 16'h0FFF);
      rd_check("mm_max_init", ADDR_MAX_SAMPLE, 16'h0000);
`else
      rd_check("mm_absent6", ADDR_MIN_SAMPLE, 16'h0000);
      rd_check("mm_absent7", ADDR_MAX_SAMPLE, 16'h0000);
      mmi_write(ADDR_MIN_SAMPLE, 16'h0123);
      rd_check("mm_absent_wr", ADDR_MIN_SAMPLE, 16'h0000);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
